// File: rtl/grb_pkg.sv
// Shared types and default timing for the GRB LED-chain shipper.
package grb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } grb_state_e;

    localparam int unsigned GRB_BITS     = 24;
    localparam int unsigned DEF_NUM_LEDS = 8;
    localparam int unsigned DEF_T0H      = 20;
    localparam int unsigned DEF_T1H      = 40;
    localparam int unsigned DEF_TBIT     = 63;
    localparam int unsigned DEF_TLATCH   = 2500;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Address width is never narrower than one bit, even for a single LED.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/grb_bit_encoder.sv
// Shared SEND/LATCH timing counter plus high/low shaping of the serial line.
module grb_bit_encoder
    import grb_pkg::*;
#(
    parameter int unsigned T0H    = DEF_T0H,
    parameter int unsigned T1H    = DEF_T1H,
    parameter int unsigned TBIT   = DEF_TBIT,
    parameter int unsigned TLATCH = DEF_TLATCH
) (
    input  logic clk,
    input  logic reset,
    input  logic sending,
    input  logic latching,
    input  logic send_next,
    input  logic latch_next,
    input  logic bit_next,
    output logic dout,
    output logic bit_end_c,
    output logic latch_end_c
);

    localparam int unsigned CW = $clog2(max_u(TBIT, TLATCH) + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt_c;
    logic [CW-1:0] high_c;

    // dout is registered from next-cycle values so it lines up with the state it belongs to.
    always_comb begin
        bit_end_c   = sending  && (cnt == CW'(TBIT - 1));
        latch_end_c = latching && (cnt == CW'(TLATCH - 1));
        high_c      = bit_next ? CW'(T1H) : CW'(T0H);
        cnt_nxt_c   = '0;
        if (send_next && sending && !bit_end_c) begin
            cnt_nxt_c = cnt + CW'(1);
        end else if (latch_next && latching) begin
            cnt_nxt_c = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            cnt  <= cnt_nxt_c;
            dout <= send_next && (cnt_nxt_c < high_c);
        end
    end

endmodule

// File: rtl/grb_shipper.sv
// Frame sequencer: fetches pixels, shifts 24 GRB bits per LED MSB first, then latches.
module grb_shipper
    import grb_pkg::*;
#(
    parameter int unsigned NUM_LEDS = DEF_NUM_LEDS,
    parameter int unsigned T0H      = DEF_T0H,
    parameter int unsigned T1H      = DEF_T1H,
    parameter int unsigned TBIT     = DEF_TBIT,
    parameter int unsigned TLATCH   = DEF_TLATCH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                shipGRB,
    input  logic [GRB_BITS-1:0]                 grb_data,
    output logic [addr_width(NUM_LEDS)-1:0]     led_addr,
    output logic                                dout,
    output logic                                Done,
    output logic                                busy
);

    localparam int unsigned AW  = addr_width(NUM_LEDS);
    localparam int unsigned BCW = $clog2(GRB_BITS);

    if (!(T0H > 0 && T0H < T1H && T1H < TBIT && TBIT >= 4 && TLATCH >= 1 &&
          NUM_LEDS >= 1 && NUM_LEDS <= 256)) begin : g_bad_params
        $error("grb_shipper: illegal NUM_LEDS/T0H/T1H/TBIT/TLATCH combination");
    end

    grb_state_e          state, state_nxt_c;
    logic [GRB_BITS-1:0] shreg, shreg_nxt_c;
    logic [BCW-1:0]      bitcnt, bitcnt_nxt_c;
    logic [AW-1:0]       led_idx, led_idx_nxt_c;
    logic [AW-1:0]       addr_nxt_c;
    logic                bit_end_c;
    logic                latch_end_c;

    grb_bit_encoder #(
        .T0H    (T0H),
        .T1H    (T1H),
        .TBIT   (TBIT),
        .TLATCH (TLATCH)
    ) u_enc (
        .clk         (clk),
        .reset       (reset),
        .sending     (state == SEND),
        .latching    (state == LATCH),
        .send_next   (state_nxt_c == SEND),
        .latch_next  (state_nxt_c == LATCH),
        .bit_next    (shreg_nxt_c[GRB_BITS-1]),
        .dout        (dout),
        .bit_end_c   (bit_end_c),
        .latch_end_c (latch_end_c)
    );

    // Next-state logic; led_addr runs one bit ahead so grb_data is ready at the LED boundary.
    always_comb begin
        state_nxt_c   = state;
        shreg_nxt_c   = shreg;
        bitcnt_nxt_c  = bitcnt;
        led_idx_nxt_c = led_idx;
        addr_nxt_c    = led_addr;
        case (state)
            IDLE: begin
                addr_nxt_c = '0;
                if (shipGRB) begin
                    state_nxt_c   = SEND;
                    shreg_nxt_c   = grb_data;
                    bitcnt_nxt_c  = '0;
                    led_idx_nxt_c = '0;
                end
            end
            SEND: begin
                if (bit_end_c) begin
                    shreg_nxt_c  = {shreg[GRB_BITS-2:0], 1'b0};
                    bitcnt_nxt_c = bitcnt + BCW'(1);
                    if (bitcnt == BCW'(GRB_BITS - 2) && led_idx != AW'(NUM_LEDS - 1)) begin
                        addr_nxt_c = led_idx + AW'(1);
                    end
                    if (bitcnt == BCW'(GRB_BITS - 1)) begin
                        bitcnt_nxt_c = '0;
                        if (led_idx == AW'(NUM_LEDS - 1)) begin
                            state_nxt_c   = LATCH;
                            addr_nxt_c    = '0;
                            led_idx_nxt_c = '0;
                        end else begin
                            shreg_nxt_c   = grb_data;
                            led_idx_nxt_c = led_idx + AW'(1);
                        end
                    end
                end
            end
            LATCH: begin
                if (latch_end_c) begin
                    state_nxt_c = DONE;
                end
            end
            DONE: begin
                state_nxt_c = IDLE;
            end
            default: begin
                state_nxt_c = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            led_idx  <= '0;
            led_addr <= '0;
            Done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt_c;
            shreg    <= shreg_nxt_c;
            bitcnt   <= bitcnt_nxt_c;
            led_idx  <= led_idx_nxt_c;
            led_addr <= addr_nxt_c;
            Done     <= (state_nxt_c == DONE);
            busy     <= (state_nxt_c != IDLE);
        end
    end

endmodule

// File: tb/tb_grb_shipper.sv
// Directed bench for grb_shipper with a short 2-LED chain and compressed timing.
module tb_grb_shipper;

    localparam int NL     = 2;
    localparam int T0H    = 2;
    localparam int T1H    = 4;
    localparam int TBIT   = 6;
    localparam int TLATCH = 10;
    localparam int NBITC  = 24 * NL * TBIT;          // 288 serial cycles
    localparam int FRAME  = 1 + NBITC + TLATCH;      // cycle index of the Done pulse

    logic        clk = 1'b0;
    logic        reset;
    logic        shipGRB;
    logic [23:0] grb_data;
    logic [0:0]  led_addr;
    logic        dout;
    logic        Done;
    logic        busy;

    logic [23:0] pix [NL];
    int          vectors     = 0;
    int          miscompares = 0;

    grb_shipper #(
        .NUM_LEDS (NL),
        .T0H      (T0H),
        .T1H      (T1H),
        .TBIT     (TBIT),
        .TLATCH   (TLATCH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .shipGRB  (shipGRB),
        .grb_data (grb_data),
        .led_addr (led_addr),
        .dout     (dout),
        .Done     (Done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Pixel store: data follows the address one cycle later.
    always @(posedge clk) grb_data <= pix[int'(led_addr)];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level in serial cycle c (1-based) of the frame.
    function automatic logic exp_dout(input int c);
        int          k;
        int          b;
        int          w;
        logic [23:0] p;
        logic        v;
        k = c - 1;
        b = k / TBIT;
        w = k % TBIT;
        p = pix[b / 24];
        v = p[23 - (b % 24)];
        return (w < (v ? T1H : T0H));
    endfunction

    task automatic chk_idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_dout", 32'(dout), 32'(0));
            chk("idle_done", 32'(Done), 32'(0));
            chk("idle_busy", 32'(busy), 32'(0));
            chk("idle_addr", 32'(led_addr), 32'(0));
            step();
        end
    endtask

    // Ship one frame; optionally hold shipGRB, pulse it again, or reset mid-frame.
    task automatic run_frame(input logic [23:0] p0, input logic [23:0] p1, input bit hold,
                             input int pulse_at, input int rst_at);
        logic ed;
        logic ea;
        pix[0] = p0;
        pix[1] = p1;
        shipGRB = 1'b0;
        step();
        step();
        shipGRB = 1'b1;
        step();
        for (int c = 1; c <= FRAME + 1; c++) begin
            ed = (c <= NBITC) ? exp_dout(c) : 1'b0;
            ea = (c >= 1 + 23 * TBIT) && (c <= NBITC);
            chk("dout", 32'(dout), 32'(ed));
            chk("led_addr", 32'(led_addr), 32'(ea));
            chk("Done", 32'(Done), 32'(c == FRAME));
            chk("busy", 32'(busy), 32'(c <= FRAME));
            if (c == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_dout", 32'(dout), 32'(0));
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_addr", 32'(led_addr), 32'(0));
                chk("rst_done", 32'(Done), 32'(0));
                step();
                step();
                reset   = 1'b0;
                shipGRB = 1'b0;
                chk_idle(FRAME - c + 20);
                return;
            end
            shipGRB = (hold && (c + 1 <= FRAME)) || (c + 1 == pulse_at);
            step();
        end
        shipGRB = 1'b0;
        chk_idle(20);
    endtask

    initial begin
        reset   = 1'b1;
        shipGRB = 1'b0;
        pix[0]  = 24'h000000;
        pix[1]  = 24'h000000;
        step();
        step();
        step();
        chk("reset_dout", 32'(dout), 32'(0));
        chk("reset_done", 32'(Done), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_addr", 32'(led_addr), 32'(0));
        reset = 1'b0;
        chk_idle(20);

        run_frame(24'hFF0000, 24'h000001, 1'b0, -1, -1);
        run_frame(24'hFF0000, 24'h000001, 1'b1, -1, -1);
        run_frame(24'h123456, 24'hABCDEF, 1'b0, 100, -1);
        run_frame(24'hA5C33C, 24'h5A0F81, 1'b0, -1, 150);
        run_frame(24'hA5C33C, 24'h5A0F81, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/grb_shipper.md
GRB_SHIPPER -- requirements
Module: grb_shipper

Interface
REQ-001 The block SHALL have one clock and asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter NUM_LEDS, default 8: LEDs in chain, range 1..256.
REQ-003 Parameter T0H, default 20: '0'-bit high time, in clk cycles.
REQ-004 Parameter T1H, default 40: '1'-bit high time, in clk cycles.
REQ-005 Parameter TBIT, default 63: total bit period, in clk cycles.
REQ-006 Parameter TLATCH, default 2500: low latch time after the last bit, in clk cycles.
REQ-007 Port clk  in  1: clock, rising edge.
REQ-008 Port reset  in  1: asynchronous, active-high reset.
REQ-009 Port shipGRB  in  1: level request to ship one full frame.
REQ-010 Port grb_data  in  24: pixel colour {G[7:0],R[7:0],B[7:0]}, valid one cycle after led_addr changes.
REQ-011 Port led_addr  out  AW=max(1,$clog2(NUM_LEDS)): pixel index being fetched.
REQ-012 Port dout  out  1: registered serial line to the LED chain.
REQ-013 Port Done  out  1: one-cycle pulse at frame completion.
REQ-014 Port busy  out  1: high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, SEND, LATCH and DONE.
REQ-016 In IDLE: led_addr=0; dout=0; shipGRB sampled high loads the shift register from grb_data; the state becomes SEND; bit 0 of LED 0 starts next cycle.
REQ-017 Each bit SHALL last exactly TBIT cycles: dout=1 for the first T1H cycles (bit=1) or T0H cycles (bit=0), then 0 for the rest.
REQ-018 Bits SHALL be sent MSB first (G7 first); 24 bits per LED; bit counter 0..23.
REQ-019 At the first cycle of bit 23 of LED k<NUM_LEDS-1, led_addr SHALL become k+1; at the end of bit 23 the shift register SHALL load grb_data; LED k+1 bit 0 follows with no gap.
REQ-020 After bit 23 of LED NUM_LEDS-1: the state SHALL become LATCH; dout=0 for exactly TLATCH cycles; led_addr returns to 0.
REQ-021 After LATCH, DONE SHALL last one cycle with Done=1, then return to IDLE.
REQ-022 shipGRB SHALL be ignored in SEND, LATCH and DONE; a new frame starts only from IDLE.
REQ-023 A frame SHALL take 1 + 24*NUM_LEDS*TBIT + TLATCH cycles from the shipGRB sample to the Done pulse inclusive.
REQ-024 Parameters SHALL satisfy 0<T0H<T1H<TBIT, TBIT>=4 and TLATCH>=1; violations SHALL be flagged by an elaboration-time check.
REQ-025 The timing counter SHALL be $clog2(max(TBIT,TLATCH)+1) bits wide and shared by SEND and LATCH.

Reset
REQ-026 Reset SHALL force, asynchronously: state=IDLE, dout=0, Done=0, busy=0, led_addr=0, and all counters and the shift register to 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no Done pulse; after release the block waits for shipGRB.

Structure
REQ-028 Package grb_pkg SHALL hold the state enum, GRB_BITS=24 and the default timing constants.
REQ-029 Sub-module grb_bit_encoder SHALL hold the bit-period counter and the high/low dout shaping, reporting bit_end to the FSM.

Verification (NUM_LEDS=2, T0H=2, T1H=4, TBIT=6, TLATCH=10)
REQ-030 Reset then idle: dout=0, Done=0, busy=0, led_addr=0 for 20 cycles with shipGRB=0.
REQ-031 Pixels 0=24'hFF0000 and 1=24'h000001, shipGRB pulse: 8 bits with 4 high/2 low, then 16 with 2 high/4 low; then 23 with 2 high/4 low and 1 with 4 high/2 low; Done on cycle 1+288+10=299.
REQ-032 At cycle 1+23*6 led_addr=1; at the end of bit 47 led_addr=0.
REQ-033 shipGRB held high through the frame and dropped the cycle after Done: exactly one frame and one Done pulse.
REQ-034 shipGRB pulsed again at cycle 100 mid-frame: no effect on dout or the Done timing.
REQ-035 Reset asserted at cycle 150 mid-frame: dout=0 immediately, no Done pulse; a later shipGRB ships a full, correct frame.
